cnn_dma_block_reader: RTL and testbench
=======================================

// Module: cnn_dma_block_reader
// PURPOSE
//  Upstream feeder of the CNN control ALU. On a request, it bursts LEN consecutive words
//  from the shared 1-cycle-latency data memory. The words go into a BLOCK_SIZE-word block
//  buffer, which is exposed in parallel on dmaOut. opDone pulses when the block is complete.
//  Serves layer-count, layer-header, filter and image reads; the ALU picks the address and length.
// PARAMETERS
//  MEM_ADDR_SIZE  20   memory word-address width
//  BLOCK_SIZE     150  block buffer depth (words)
//  DATA_SIZE      16   memory/data word width
//  LEN_W          8    width of length request (must hold BLOCK_SIZE)
// PORTS
//  clk        in   1                        single clock, all state on posedge
//  reset      in   1                        asynchronous, active-low reset
//  dmaEnable  in   1                        transfer request (level; edge-armed, see below)
//  address    in   MEM_ADDR_SIZE            start word address, sampled at accept
//  length     in   LEN_W                    words to read, sampled at accept
//  mem_addr   out  MEM_ADDR_SIZE            memory read address
//  mem_rd     out  1                        memory read strobe
//  mem_rdata  in   DATA_SIZE                read data, valid the cycle after mem_rd
//  dmaOut     out  DATA_SIZE x BLOCK_SIZE   block buffer, index 0 = word at address
//  busy       out  1                        high from accept until opDone inclusive
//  opDone     out  1                        one-cycle completion pulse
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE.
//   - Outputs cleared: mem_addr=0, mem_rd=0, busy=0, opDone=0, all dmaOut=0.
//   - armed=1.
//   - A reset mid-transfer aborts it; no opDone is produced.
//  States: IDLE -> READ -> DRAIN -> DONE -> IDLE.
//  Accept: edge T0 with state IDLE, dmaEnable=1, armed=1.
//   - Latch base=address.
//   - Latch N = min(length, BLOCK_SIZE).
//   - Zero every dmaOut entry.
//   - Set busy=1 and armed=0.
//   - Go to READ; if N==0, go to DONE directly.
//  READ, cycles 1..N after T0: cycle k drives mem_rd=1, mem_addr=base+k-1.
//   - Address arithmetic is modulo 2^MEM_ADDR_SIZE; the wrap is silent.
//   - After the cycle-N issue, go to DRAIN.
//  Capture: mem_rdata of cycle k+1 is written to dmaOut[k-1] at the end of that cycle.
//   - The capture pipeline overlaps READ, so there is one capture per issued read.
//   - DRAIN (cycle N+1) performs the last capture with mem_rd=0.
//  DONE (cycle N+2): opDone=1 for exactly one cycle, busy still 1; next state IDLE.
//   - N==0: DONE is cycle 1.
//  Latency: accept to opDone = N+2 cycles (1 cycle for N==0). Throughput: 1 word/cycle.
//  dmaOut holds the completed block stable until the next accept.
//   - Entries >= N read 0.
//  Re-arm: armed is set again only after dmaEnable is sampled 0 while IDLE.
//   - A level held high across opDone does not retrigger.
//  Sampling: dmaEnable, address and length are ignored while busy.
//   - Dropping dmaEnable mid-transfer does not abort; opDone still fires.
//  Simultaneous events: an accept in the cycle after opDone is legal only if re-armed.
//  Counters: word counter and capture index are LEN_W wide; overflow is impossible after the clamp.
// STRUCTURE
//  cnn_pkg, shared package:
//   - MEM_ADDR_SIZE, BLOCK_SIZE, DATA_SIZE localparams.
//   - typedef dma_state_e {IDLE, READ, DRAIN, DONE}.
//   - typedef data_word_t logic [DATA_SIZE-1:0].
//  Sub-module cnn_dma_addr_gen: base/count address generator that emits mem_addr, mem_rd, last.
//  Capture pipeline and buffer stay in the top.
// TESTING
//  Setup: memory model with mem[i]=i+16'h100, 1-cycle read latency.
//  1. Layer-count read: address=1, length=1.
//     - dmaOut[0]=16'h101, dmaOut[1..149]=0.
//     - opDone exactly 3 cycles after accept.
//  2. Header read: address=2, length=3.
//     - dmaOut[0..2]=16'h102..16'h104.
//     - mem_rd high for exactly 3 cycles at addresses 2,3,4.
//  3. Length 200: clamped to 150.
//     - dmaOut[149]=mem[address+149].
//     - opDone at accept+152.
//     - No read is issued to address+150.
//  4. Wrap: address=20'hFFFFE, length=4.
//     - mem_addr sequence FFFFE, FFFFF, 00000, 00001.
//  5. Level hold: dmaEnable held high 20 cycles, length=2.
//     - A single opDone pulse.
//     - Drop dmaEnable, raise it again: a second transfer starts.
//  6. Async reset at cycle 3 of a length-10 read.
//     - Outputs zero immediately.
//     - No opDone.
//     - The next request behaves normally.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and sizing for the CNN DMA block reader and its address generator.
package cnn_pkg;

  localparam int unsigned MEM_ADDR_SIZE = 20;
  localparam int unsigned BLOCK_SIZE    = 150;
  localparam int unsigned DATA_SIZE     = 16;
  localparam int unsigned LEN_W         = 8;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} dma_state_e;

  typedef logic [DATA_SIZE-1:0]     data_word_t;
  typedef logic [MEM_ADDR_SIZE-1:0] mem_addr_t;
  typedef logic [LEN_W-1:0]         len_t;

  // Request captured at accept: start word address and (clamped) word count
  typedef struct packed {
    mem_addr_t base;
    len_t      len;
  } dma_req_t;

  function automatic len_t clamp_len(input len_t len);
    return (32'(len) > BLOCK_SIZE) ? LEN_W'(BLOCK_SIZE) : len;
  endfunction

endpackage

// File: rtl/cnn_dma_block_reader_if.sv
// Read port of the shared 1-cycle-latency data memory.
interface cnn_dma_block_reader_if;
  import cnn_pkg::*;

  mem_addr_t  mem_addr;
  logic       mem_rd;
  data_word_t mem_rdata;

  modport master (output mem_addr, output mem_rd, input mem_rdata);
  modport slave  (input mem_addr, input mem_rd, output mem_rdata);

endinterface

// File: rtl/cnn_dma_addr_gen.sv
// Burst address generator: one read strobe per cycle from base for len words.
module cnn_dma_addr_gen
  import cnn_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      start,
  input  dma_req_t  req,
  output mem_addr_t mem_addr,
  output logic      mem_rd,
  output logic      last_c
);

  mem_addr_t addr_q, addr_d;
  len_t      rem_q,  rem_d;
  logic      rd_q,   rd_d;

  // rem_q counts reads still to issue after the current one
  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    rd_d   = rd_q;
    if (start && (req.len != '0)) begin
      addr_d = req.base;
      rem_d  = req.len - LEN_W'(1);
      rd_d   = 1'b1;
    end else if (rd_q) begin
      if (rem_q == '0) begin
        rd_d = 1'b0;
      end else begin
        addr_d = addr_q + MEM_ADDR_SIZE'(1);
        rem_d  = rem_q - LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      rem_q  <= '0;
      rd_q   <= 1'b0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
      rd_q   <= rd_d;
    end
  end

  assign mem_addr = addr_q;
  assign mem_rd   = rd_q;
  assign last_c   = rd_q && (rem_q == '0);

endmodule

// File: rtl/cnn_dma_block_reader.sv
// Bursts up to BLOCK_SIZE consecutive memory words into a parallel block buffer
// on an edge-armed request; opDone pulses once the last word has landed.
module cnn_dma_block_reader
  import cnn_pkg::*;
(
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                dmaEnable,
  input  mem_addr_t                           address,
  input  len_t                                length,
  cnn_dma_block_reader_if.master              mem,
  output logic [BLOCK_SIZE-1:0][DATA_SIZE-1:0] dmaOut,
  output logic                                busy,
  output logic                                opDone
);

  dma_state_e state_q, state_d;
  logic       armed_q, armed_d;
  logic       busy_q, busy_d;
  logic       op_done_q, op_done_d;
  logic       cap_vld_q, cap_vld_d;
  len_t       cap_idx_q, cap_idx_d;
  logic [BLOCK_SIZE-1:0][DATA_SIZE-1:0] buf_q, buf_d;

  logic      accept_c;
  dma_req_t  req_c;
  mem_addr_t ag_addr;
  logic      ag_rd;
  logic      ag_last_c;

  assign accept_c = (state_q == IDLE) && dmaEnable && armed_q;
  assign req_c    = '{base: address, len: clamp_len(length)};

  cnn_dma_addr_gen u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .start    (accept_c),
    .req      (req_c),
    .mem_addr (ag_addr),
    .mem_rd   (ag_rd),
    .last_c   (ag_last_c)
  );

  // Transfer sequencing; a level held across completion stays disarmed until seen low
  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    busy_d    = busy_q;
    op_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          busy_d  = 1'b1;
          armed_d = 1'b0;
          if (req_c.len == '0) begin
            state_d   = DONE;
            op_done_d = 1'b1;
          end else begin
            state_d = READ;
          end
        end else if (!dmaEnable) begin
          armed_d = 1'b1;
        end
      end
      READ: begin
        if (ag_last_c) state_d = DRAIN;
      end
      DRAIN: begin
        state_d   = DONE;
        op_done_d = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture pipeline: read data arrives one cycle after its strobe
  always_comb begin
    cap_vld_d = ag_rd;
    cap_idx_d = cap_idx_q;
    buf_d     = buf_q;
    if (accept_c) begin
      cap_idx_d = '0;
      buf_d     = '0;
    end else if (cap_vld_q) begin
      for (int i = 0; i < int'(BLOCK_SIZE); i++) begin
        if (cap_idx_q == LEN_W'(i)) buf_d[i] = mem.mem_rdata;
      end
      cap_idx_d = cap_idx_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      armed_q   <= 1'b1;
      busy_q    <= 1'b0;
      op_done_q <= 1'b0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
      buf_q     <= '0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      busy_q    <= busy_d;
      op_done_q <= op_done_d;
      cap_vld_q <= cap_vld_d;
      cap_idx_q <= cap_idx_d;
      buf_q     <= buf_d;
    end
  end

  assign mem.mem_addr = ag_addr;
  assign mem.mem_rd   = ag_rd;
  assign dmaOut       = buf_q;
  assign busy         = busy_q;
  assign opDone       = op_done_q;

endmodule

// File: tb/tb_cnn_dma_block_reader.sv
// Directed bench for cnn_dma_block_reader against a mem[i] = i + 16'h100 memory model.
module tb_cnn_dma_block_reader;
  import cnn_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n;
  logic      dma_enable;
  mem_addr_t address;
  len_t      length;
  logic [BLOCK_SIZE-1:0][DATA_SIZE-1:0] dma_out;
  logic      busy;
  logic      op_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  mem_addr_t rd_addr_q[$];
  int        rd_cyc_q[$];
  int        done_cyc_q[$];
  logic      done_busy_q[$];

  cnn_dma_block_reader_if mem_if ();

  cnn_dma_block_reader dut (
    .clk       (clk),
    .reset     (rst_n),
    .dmaEnable (dma_enable),
    .address   (address),
    .length    (length),
    .mem       (mem_if.master),
    .dmaOut    (dma_out),
    .busy      (busy),
    .opDone    (op_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: 1-cycle read latency, mem[i] = i + 0x100 (16-bit)
  always @(posedge clk) begin
    if (mem_if.mem_rd) mem_if.mem_rdata <= 16'(mem_if.mem_addr) + 16'h100;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_if.mem_rd) begin
        rd_addr_q.push_back(mem_if.mem_addr);
        rd_cyc_q.push_back(cyc);
      end
      if (op_done) begin
        done_cyc_q.push_back(cyc);
        done_busy_q.push_back(busy);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] or_from(input int lo);
    logic [15:0] r = '0;
    for (int i = lo; i < int'(BLOCK_SIZE); i++) r |= dma_out[i];
    return r;
  endfunction

  function automatic int done_lat(input int t0);
    return (done_cyc_q.size() > 0) ? done_cyc_q[0] - t0 : -1;
  endfunction

  function automatic int rd_cyc_at(input int i);
    return (rd_cyc_q.size() > i) ? rd_cyc_q[i] : -1;
  endfunction

  function automatic mem_addr_t rd_addr_at(input int i);
    return (rd_addr_q.size() > i) ? rd_addr_q[i] : '1;
  endfunction

  task automatic clear_logs();
    rd_addr_q.delete();
    rd_cyc_q.delete();
    done_cyc_q.delete();
    done_busy_q.delete();
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (done_cyc_q.size() == 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (done_cyc_q.size() == 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_xfer(input mem_addr_t a, input len_t l, output int t0);
    @(negedge clk);
    clear_logs();
    address    = a;
    length     = l;
    dma_enable = 1'b1;
    t0         = cyc;
    @(negedge clk);
    dma_enable = 1'b0;
    wait_done(300);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int t0;
    rst_n      = 1'b0;
    dma_enable = 1'b0;
    address    = '0;
    length     = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",    32'(busy), 32'd0);
    chk("rst_opdone",  32'(op_done), 32'd0);
    chk("rst_mem_rd",  32'(mem_if.mem_rd), 32'd0);
    chk("rst_mem_addr", 32'(mem_if.mem_addr), 32'd0);
    chk("rst_dmaout",  32'(or_from(0)), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1. layer-count read
    do_xfer(20'h1, 8'd1, t0);
    chk("t1_word0",     32'(dma_out[0]), 32'h101);
    chk("t1_rest_zero", 32'(or_from(1)), 32'd0);
    chk("t1_done_lat",  32'(done_lat(t0)), 32'd3);
    chk("t1_done_cnt",  32'(done_cyc_q.size()), 32'd1);
    chk("t1_busy_at_done", 32'(done_busy_q.size() > 0 && done_busy_q[0]), 32'd1);
    chk("t1_busy_after", 32'(busy), 32'd0);

    // 2. header read
    do_xfer(20'h2, 8'd3, t0);
    chk("t2_word0", 32'(dma_out[0]), 32'h102);
    chk("t2_word1", 32'(dma_out[1]), 32'h103);
    chk("t2_word2", 32'(dma_out[2]), 32'h104);
    chk("t2_rd_cnt", 32'(rd_addr_q.size()), 32'd3);
    chk("t2_rd_a0", 32'(rd_addr_at(0)), 32'h2);
    chk("t2_rd_a1", 32'(rd_addr_at(1)), 32'h3);
    chk("t2_rd_a2", 32'(rd_addr_at(2)), 32'h4);
    chk("t2_rd_first_cyc", 32'(rd_cyc_at(0) - t0), 32'd1);
    chk("t2_rd_last_cyc",  32'(rd_cyc_at(2) - t0), 32'd3);
    chk("t2_done_lat", 32'(done_lat(t0)), 32'd5);

    // 3. clamp 200 -> 150
    do_xfer(20'h10, 8'd200, t0);
    chk("t3_word0",   32'(dma_out[0]), 32'h110);
    chk("t3_word75",  32'(dma_out[75]), 32'h15B);
    chk("t3_word149", 32'(dma_out[149]), 32'h1A5);
    chk("t3_done_lat", 32'(done_lat(t0)), 32'd152);
    chk("t3_rd_cnt", 32'(rd_addr_q.size()), 32'd150);
    chk("t3_rd_last", 32'(rd_addr_at(149)), 32'hA5);

    // 4. address wrap, and buffer re-zeroed at accept
    do_xfer(20'hFFFFE, 8'd4, t0);
    chk("t4_rd_a0", 32'(rd_addr_at(0)), 32'hFFFFE);
    chk("t4_rd_a1", 32'(rd_addr_at(1)), 32'hFFFFF);
    chk("t4_rd_a2", 32'(rd_addr_at(2)), 32'h00000);
    chk("t4_rd_a3", 32'(rd_addr_at(3)), 32'h00001);
    chk("t4_word0", 32'(dma_out[0]), 32'h00FE);
    chk("t4_word3", 32'(dma_out[3]), 32'h0101);
    chk("t4_rest_zero", 32'(or_from(4)), 32'd0);
    chk("t4_done_lat", 32'(done_lat(t0)), 32'd6);

    // zero-length request completes in one cycle with no reads
    do_xfer(20'h3, 8'd0, t0);
    chk("t0len_done_lat", 32'(done_lat(t0)), 32'd1);
    chk("t0len_rd_cnt", 32'(rd_addr_q.size()), 32'd0);
    chk("t0len_all_zero", 32'(or_from(0)), 32'd0);

    // 5. level hold: single transfer, re-arm after drop
    @(negedge clk);
    clear_logs();
    address    = 20'h5;
    length     = 8'd2;
    dma_enable = 1'b1;
    t0         = cyc;
    repeat (20) @(negedge clk);
    chk("t5_done_cnt", 32'(done_cyc_q.size()), 32'd1);
    chk("t5_done_lat", 32'(done_lat(t0)), 32'd4);
    chk("t5_rd_cnt", 32'(rd_addr_q.size()), 32'd2);
    chk("t5_word1", 32'(dma_out[1]), 32'h106);
    dma_enable = 1'b0;
    repeat (2) @(negedge clk);
    do_xfer(20'h7, 8'd2, t0);
    chk("t5b_done_lat", 32'(done_lat(t0)), 32'd4);
    chk("t5b_word0", 32'(dma_out[0]), 32'h107);
    chk("t5b_word1", 32'(dma_out[1]), 32'h108);

    // 6. async reset at cycle 3 of a length-10 read
    @(negedge clk);
    clear_logs();
    address    = 20'h20;
    length     = 8'd10;
    dma_enable = 1'b1;
    @(negedge clk);
    dma_enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_pre_word0", 32'(dma_out[0]), 32'h120);
    chk("t6_pre_mem_rd", 32'(mem_if.mem_rd), 32'd1);
    chk("t6_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_mem_rd", 32'(mem_if.mem_rd), 32'd0);
    chk("t6_rst_mem_addr", 32'(mem_if.mem_addr), 32'd0);
    chk("t6_rst_dmaout", 32'(or_from(0)), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("t6_no_done", 32'(done_cyc_q.size()), 32'd0);
    do_xfer(20'h30, 8'd2, t0);
    chk("t6_after_done_lat", 32'(done_lat(t0)), 32'd4);
    chk("t6_after_word1", 32'(dma_out[1]), 32'h131);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
